ghash_tag_verify: RTL and testbench
===================================

Name: ghash_tag_verify

Overview:
Receive-side GCM authenticator, the counterpart of the transmit-side tag generator.
- Absorbs a stream of 128-bit AAD and ciphertext blocks and accumulates GHASH with a digit-serial GF(2^128) multiplier.
- Appends the length block and XORs the result with E_K(J0).
- Compares against the received tag and reports pass/fail.
- Sits after the AES-CTR decrypt datapath; gates release of plaintext.

Parameters:
- DIGIT, 8, multiplier bits consumed per cycle; legal values 1, 2, 4, 8, 16. MUL_CYC = 128/DIGIT.
- TAG_W, 128, number of tag MSBs compared: tag[0:TAG_W-1]. Legal values 96 to 128 in steps of 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches h_key, ekj0, len_aad, len_ct. Ignored unless in IDLE or DONE.
- h_key  in  [0:127]  hash subkey H = E_K(0^128).
- ekj0  in  [0:127]  E_K(J0).
- len_aad  in  [0:63]  AAD length in bits.
- len_ct  in  [0:63]  ciphertext length in bits.
- s_valid  in  1  block valid.
- s_ready  out  1  block accepted when s_valid && s_ready.
- s_data  in  [0:127]  AAD/ciphertext block; partial blocks are zero-padded upstream.
- s_last  in  1  marks the final data block.
- rx_tag  in  [0:127]  received tag; sampled in FINAL.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the result is valid.
- tag_ok  out  1  compare result; held until the next start.
- tag_calc  out  [0:127]  computed tag; held until the next start.

Behaviour:
- Bit order follows GCM: index 0 is the x^0 coefficient (MSB of the byte string). R = 8'hE1 followed by 120 zeros.
- Multiply step, DIGIT iterations per cycle:
  - if X[i], then Z ^= V;
  - V = V[127] ? ({1'b0, V[0:126]} ^ R) : {1'b0, V[0:126]}.
- Reset: state IDLE; Y, tag_calc, s_ready, busy, done, tag_ok all 0.
- FSM states: IDLE, ACCEPT, MUL, LENMUL, FINAL, DONE.
  - IDLE/DONE, on start: latch inputs; Y <= 0; go to ACCEPT; tag_ok <= 0.
  - ACCEPT: s_ready = 1.
    - If len_aad == 0 and len_ct == 0: skip directly to LENMUL with X = Y ^ {len_aad, len_ct}; no block is accepted.
    - On handshake: X <= Y ^ s_data; counter <= 0; remember s_last; go to MUL.
  - MUL: s_ready = 0; run MUL_CYC cycles. At end, Y <= Z. Then go to ACCEPT if the remembered last was 0, else LENMUL.
  - LENMUL: X = Y ^ {len_aad, len_ct}; MUL_CYC cycles; Y <= Z.
  - FINAL (1 cycle): tag_calc <= Y ^ ekj0; tag_ok <= (Y ^ ekj0)[0:TAG_W-1] == rx_tag[0:TAG_W-1].
  - DONE: done = 1 for exactly the first cycle, then stays in DONE until start.
- Latency per data block: 1 accept cycle + MUL_CYC.
- Latency from last block handshake to done: 2*MUL_CYC + 2.
- Block counts are not cross-checked against the lengths; upstream owns framing.
- start while busy: ignored; no state change.
- s_valid while not ready: held by the source and not consumed.
- rst_n deasserted mid-operation: asynchronous return to the reset state; no done pulse.
- done and a new start in the same cycle: start is accepted; done still pulses this cycle.

Decomposition:
- Package gcm_pkg:
  - typedef logic [0:127] blk_t;
  - constant GF128_R;
  - typedef enum for the FSM states;
  - function gf128_step(Z, V, xbit).
- Sub-module gf128_mul_serial, parameterised by DIGIT:
  - ports: clk, rst_n, go, x, y, busy, done, z;
  - shared with the future serial transmit-side GHASH.

Test Plan:
- NIST GCM case 1: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ekj0=58e2fccefa7e3061367f1d57a4e7455a, lengths 0/0, rx_tag = ekj0. Expect tag_calc=58e2fccefa7e3061367f1d57a4e7455a, tag_ok=1, no s_ready handshake, done at start+MUL_CYC+2.
- NIST GCM case 2: same H and ekj0, one block C=0388dace60b6a392f328c2b971b2fe78, len_ct=128. Expect tag_calc=ab6e47d42cec13bdf53a67b21257bddf, tag_ok=1; with rx_tag bit 127 flipped, tag_ok=0.
- Case 2 with TAG_W=96 and rx_tag low 32 bits corrupted. Expect tag_ok=1.
- Back-pressure: s_valid toggling randomly, and a second block offered during MUL. Expect s_ready=0 during MUL, every block consumed exactly once, result identical to the gap-free run.
- Reset mid-MUL, then rerun case 2. Expect outputs 0 immediately on rst_n low, then a correct tag with no stale state.
- start pulsed while busy. Expect it ignored and the original run's result unchanged; repeat for DIGIT=1 and DIGIT=16.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared GCM types and the single-bit GF(2^128) multiply step used by the
// serial GHASH engines on both the transmit and receive sides.
package gcm_pkg;

  // Index 0 is the x^0 coefficient, i.e. the MSB of the byte string.
  typedef logic [0:127] blk_t;

  // Reduction constant: 8'hE1 followed by 120 zeros.
  localparam blk_t GF128_R = {8'he1, 120'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_MUL,
    ST_LENMUL,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Running accumulator and shifted multiplicand of the serial multiply.
  typedef struct packed {
    blk_t z;
    blk_t v;
  } gf_zv_t;

  // One multiplier bit: conditionally accumulate V, then V *= x mod P.
  function automatic gf_zv_t gf128_step(input blk_t z, input blk_t v, input logic xbit);
    gf_zv_t r;
    r.z = xbit ? (z ^ v) : z;
    r.v = v[127] ? ({1'b0, v[0:126]} ^ GF128_R) : {1'b0, v[0:126]};
    return r;
  endfunction

endpackage

// File: rtl/gf128_mul_serial.sv
// Digit-serial GF(2^128) multiplier, z = x * y. A go pulse while idle loads
// the operands; the product appears on z during the cycle done is high,
// which is the last of 128/DIGIT busy cycles.
module gf128_mul_serial
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  blk_t x,
  input  blk_t y,
  output logic busy,
  output logic done,
  output blk_t z
);

  localparam int MUL_CYC = 128 / DIGIT;
  localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  blk_t             x_q;
  blk_t             z_q;
  blk_t             v_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             last;
  gf_zv_t           acc;

  // Apply DIGIT multiply steps to the current accumulator in one cycle.
  // NOTE: every always_comb output gets a value before any branch or loop, so no latch can be inferred.
  always_comb begin
    acc.z = z_q;
    acc.v = v_q;
    for (int i = 0; i < DIGIT; i++) begin
      acc = gf128_step(acc.z, acc.v, x_q[i]);
    end
  end

  assign last = (cnt_q == CNT_W'(MUL_CYC - 1));

  // Operand load on go, then one digit per cycle; x shifts toward index 0.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the wide datapath registers are plain flops, not RAM, so they are cleared with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      z_q    <= '0;
      v_q    <= '0;
    end else if (go && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      x_q    <= x;
      z_q    <= '0;
      v_q    <= y;
    end else if (busy_q) begin
      z_q   <= acc.z;
      v_q   <= acc.v;
      x_q   <= x_q << DIGIT;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && last;
  assign z    = acc.z;

endmodule

// File: rtl/ghash_tag_verify.sv
// Receive-side GCM authenticator: folds AAD/ciphertext blocks into GHASH,
// folds in the length block, masks with E_K(J0) and compares the leading
// TAG_W bits against the received tag.
module ghash_tag_verify
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8,
  parameter int TAG_W = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  blk_t        h_key,
  input  blk_t        ekj0,
  input  logic [0:63] len_aad,
  input  logic [0:63] len_ct,
  input  logic        s_valid,
  output logic        s_ready,
  input  blk_t        s_data,
  input  logic        s_last,
  input  blk_t        rx_tag,
  output logic        busy,
  output logic        done,
  output logic        tag_ok,
  output blk_t        tag_calc
);

  state_t      state_q;
  state_t      state_d;
  blk_t        h_q;
  blk_t        ekj0_q;
  blk_t        y_q;
  logic [0:63] len_aad_q;
  logic [0:63] len_ct_q;
  logic        last_q;

  logic        mul_go;
  logic        mul_busy;
  logic        mul_done;
  blk_t        mul_x;
  blk_t        mul_z;

  logic        zero_len;
  blk_t        len_blk;
  blk_t        tag_nxt;

  assign zero_len = (len_aad_q == '0) && (len_ct_q == '0);
  assign len_blk  = {len_aad_q, len_ct_q};
  assign tag_nxt  = y_q ^ ekj0_q;

  gf128_mul_serial #(.DIGIT(DIGIT)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (mul_go),
    .x    (mul_x),
    .y    (h_q),
    .busy (mul_busy),
    .done (mul_done),
    .z    (mul_z)
  );

  // Next state, block handshake and multiplier launch.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    mul_go  = 1'b0;
    mul_x   = y_q ^ len_blk;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        if (zero_len) begin
          // Empty message: go straight to the length block.
          mul_go  = 1'b1;
          state_d = ST_LENMUL;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            mul_go  = 1'b1;
            mul_x   = y_q ^ s_data;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = last_q ? ST_LENMUL : ST_ACCEPT;
      end
      ST_LENMUL: begin
        // Coming from MUL the multiplier is idle here and Y holds the final
        // data hash; on the empty-message path it was already launched.
        mul_go = !mul_busy;
        if (mul_done) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand latching, GHASH accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      ekj0_q    <= '0;
      len_aad_q <= '0;
      len_ct_q  <= '0;
      y_q       <= '0;
      last_q    <= 1'b0;
      done      <= 1'b0;
      tag_ok    <= 1'b0;
      tag_calc  <= '0;
    end else begin
      done <= (state_q == ST_FINAL);
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            h_q       <= h_key;
            ekj0_q    <= ekj0;
            len_aad_q <= len_aad;
            len_ct_q  <= len_ct;
            y_q       <= '0;
            tag_ok    <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (s_ready && s_valid) last_q <= s_last;
        end
        ST_MUL, ST_LENMUL: begin
          if (mul_done) y_q <= mul_z;
        end
        ST_FINAL: begin
          tag_calc <= tag_nxt;
          tag_ok   <= (tag_nxt[0:TAG_W-1] == rx_tag[0:TAG_W-1]);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_ghash_tag_verify.sv
// Bench for ghash_tag_verify: three instances (DIGIT/TAG_W = 8/128, 1/96,
// 16/128) driven by directed NIST vectors and random messages, checked
// against a whole-message GHASH reference model.
module tb_ghash_tag_verify;
  import gcm_pkg::*;

  localparam int N = 3;

  localparam logic [127:0] NIST_H  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] NIST_EK = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] NIST_C  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] NIST_T2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start    [N];
  blk_t        h_key    [N];
  blk_t        ekj0     [N];
  logic [0:63] len_aad  [N];
  logic [0:63] len_ct   [N];
  logic        s_valid  [N];
  logic        s_ready  [N];
  blk_t        s_data   [N];
  logic        s_last   [N];
  blk_t        rx_tag   [N];
  logic        busy     [N];
  logic        done     [N];
  logic        tag_ok   [N];
  blk_t        tag_calc [N];

  int   checks   = 0;
  int   failures = 0;
  blk_t blkq[$];

  always #5 clk = ~clk;

  ghash_tag_verify #(.DIGIT(8), .TAG_W(128)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .h_key(h_key[0]), .ekj0(ekj0[0]),
    .len_aad(len_aad[0]), .len_ct(len_ct[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_last(s_last[0]), .rx_tag(rx_tag[0]), .busy(busy[0]),
    .done(done[0]), .tag_ok(tag_ok[0]), .tag_calc(tag_calc[0])
  );

  ghash_tag_verify #(.DIGIT(1), .TAG_W(96)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .h_key(h_key[1]), .ekj0(ekj0[1]),
    .len_aad(len_aad[1]), .len_ct(len_ct[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_last(s_last[1]), .rx_tag(rx_tag[1]), .busy(busy[1]),
    .done(done[1]), .tag_ok(tag_ok[1]), .tag_calc(tag_calc[1])
  );

  ghash_tag_verify #(.DIGIT(16), .TAG_W(128)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .h_key(h_key[2]), .ekj0(ekj0[2]),
    .len_aad(len_aad[2]), .len_ct(len_ct[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_data(s_data[2]), .s_last(s_last[2]), .rx_tag(rx_tag[2]), .busy(busy[2]),
    .done(done[2]), .tag_ok(tag_ok[2]), .tag_calc(tag_calc[2])
  );

  function automatic int mul_cyc(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 128 : 8);
  endfunction

  function automatic int tag_w(input int k);
    return (k == 1) ? 96 : 128;
  endfunction

  function automatic blk_t rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Textbook GCM product: walk a's bits from x^0 upward, shifting b by x.
  function automatic blk_t ref_mul(input blk_t a, input blk_t b);
    blk_t zz;
    blk_t vv;
    blk_t rr;
    zz = '0;
    vv = b;
    rr = {8'he1, 120'd0};
    for (int i = 0; i < 128; i++) begin
      if (a[i]) zz = zz ^ vv;
      vv = vv[127] ? ((vv >> 1) ^ rr) : (vv >> 1);
    end
    return zz;
  endfunction

  // GHASH over the queued blocks plus the length block, masked with E_K(J0).
  function automatic blk_t ref_tag(input blk_t hk, input blk_t ek,
                                   input logic [0:63] la, input logic [0:63] lc);
    blk_t acc;
    acc = '0;
    foreach (blkq[i]) acc = ref_mul(acc ^ blkq[i], hk);
    acc = ref_mul(acc ^ {la, lc}, hk);
    return acc ^ ek;
  endfunction

  // Only the leading tw bits (indices 0..tw-1) take part in the compare.
  function automatic logic ref_ok(input int tw, input blk_t t, input blk_t r);
    blk_t m;
    m = '1;
    m = m << (128 - tw);
    return ((t ^ r) & m) == '0;
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One full message on instance k. Returns in the cycle done is high.
  task automatic run_txn(input int k, input blk_t hk, input blk_t ek,
                         input logic [0:63] la, input logic [0:63] lc, input blk_t rx,
                         input bit gaps, input bit poke, input string name);
    blk_t exp_tag;
    int   m;
    int   n;
    int   guard;
    bit   hs;
    bit   saw_ready;
    m       = mul_cyc(k);
    exp_tag = ref_tag(hk, ek, la, lc);
    h_key[k]   = hk;
    ekj0[k]    = ek;
    len_aad[k] = la;
    len_ct[k]  = lc;
    rx_tag[k]  = rx;
    start[k]   = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    // Inputs other than rx_tag must have been latched by start.
    h_key[k]   = rand128();
    ekj0[k]    = rand128();
    len_aad[k] = {$urandom(), $urandom()};
    len_ct[k]  = {$urandom(), $urandom()};
    check({name, "_busy"}, 128'(busy[k]), 128'(1));
    n         = 0;
    saw_ready = 1'b0;
    foreach (blkq[i]) begin
      s_data[k] = blkq[i];
      s_last[k] = (i == blkq.size() - 1);
      guard     = 0;
      hs        = 1'b0;
      while (!hs && guard < 8 * m + 20) begin
        s_valid[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        hs         = s_valid[k] && s_ready[k];
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) begin
        check({name, "_accept_timeout"}, 128'(0), 128'(1));
        s_valid[k] = 1'b0;
        return;
      end
      n = 0;
      // Offer the next block straight away; it must wait out the multiply.
      if (i < blkq.size() - 1) begin
        s_valid[k] = 1'b1;
        s_data[k]  = blkq[i + 1];
        s_last[k]  = (i + 1 == blkq.size() - 1);
      end else begin
        s_valid[k] = 1'b0;
      end
      check({name, "_no_ready_in_mul"}, 128'(s_ready[k]), 128'(0));
      if (poke && i == 0) begin
        start[k] = 1'b1;
        @(posedge clk); #1;
        n++;
        start[k] = 1'b0;
        check({name, "_start_ignored"}, 128'({busy[k], s_ready[k]}), 128'(2'b10));
      end
    end
    s_valid[k] = 1'b0;
    guard      = 0;
    while (!done[k] && guard < 4 * m + 20) begin
      if (s_ready[k]) saw_ready = 1'b1;
      @(posedge clk); #1;
      n++;
      guard++;
    end
    check({name, "_done"}, 128'(done[k]), 128'(1));
    check({name, "_latency"}, 128'(n), 128'((blkq.size() == 0) ? m + 2 : 2 * m + 2));
    check({name, "_tag"}, tag_calc[k], exp_tag);
    check({name, "_ok"}, 128'(tag_ok[k]), 128'(ref_ok(tag_w(k), exp_tag, rx)));
    check({name, "_idle_busy"}, 128'(busy[k]), 128'(0));
    if (blkq.size() == 0) check({name, "_no_handshake"}, 128'(saw_ready), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t        t;
    blk_t        rx;
    int          k;
    int          nb;
    logic [0:63] la;
    logic [0:63] lc;
    bit          ok_hs;

    for (int i = 0; i < N; i++) begin
      start[i]   = 1'b0;
      h_key[i]   = '0;
      ekj0[i]    = '0;
      len_aad[i] = '0;
      len_ct[i]  = '0;
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_last[i]  = 1'b0;
      rx_tag[i]  = '0;
    end

    // Reset values.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("reset_outputs", 128'({busy[i], done[i], tag_ok[i], s_ready[i]}), 128'(0));
      check("reset_tag_calc", tag_calc[i], 128'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // NIST case 1: empty message, tag equals E_K(J0).
    blkq = {};
    run_txn(0, NIST_H, NIST_EK, 64'd0, 64'd0, NIST_EK, 1'b0, 1'b0, "nist1");
    check("nist1_const", tag_calc[0], NIST_EK);
    check("nist1_ok", 128'(tag_ok[0]), 128'(1));
    @(posedge clk); #1;
    check("nist1_done_pulse", 128'(done[0]), 128'(0));
    check("nist1_ok_held", 128'(tag_ok[0]), 128'(1));

    // NIST case 2: one ciphertext block.
    blkq = {NIST_C};
    run_txn(0, NIST_H, NIST_EK, 64'd0, 64'd128, NIST_T2, 1'b0, 1'b0, "nist2");
    check("nist2_const", tag_calc[0], NIST_T2);
    check("nist2_ok", 128'(tag_ok[0]), 128'(1));
    // done and start coincide: the new run is taken in the done cycle.
    check("b2b_done_high", 128'(done[0]), 128'(1));
    run_txn(0, NIST_H, NIST_EK, 64'd0, 64'd128, NIST_T2 ^ 128'h1, 1'b0, 1'b0, "nist2_flip127");
    check("nist2_flip127_ok", 128'(tag_ok[0]), 128'(0));

    // Truncated compare: low 32 bits do not matter, bit 95 does.
    run_txn(1, NIST_H, NIST_EK, 64'd0, 64'd128, NIST_T2 ^ 128'hffffffff, 1'b0, 1'b0, "t96_low32");
    check("t96_low32_ok", 128'(tag_ok[1]), 128'(1));
    check("t96_low32_const", tag_calc[1], NIST_T2);
    run_txn(1, NIST_H, NIST_EK, 64'd0, 64'd128, NIST_T2 ^ (128'h1 << 32), 1'b0, 1'b0, "t96_bit95");
    check("t96_bit95_ok", 128'(tag_ok[1]), 128'(0));

    // Back-pressure: same message with and without random s_valid gaps.
    blkq = {};
    for (int i = 0; i < 4; i++) blkq.push_back(rand128());
    t  = rand128();
    rx = rand128();
    run_txn(0, t, rx, 64'd256, 64'd256, ref_tag(t, rx, 64'd256, 64'd256), 1'b0, 1'b0, "bp_nogap");
    run_txn(0, t, rx, 64'd256, 64'd256, ref_tag(t, rx, 64'd256, 64'd256), 1'b1, 1'b0, "bp_gaps");

    // Reset in the middle of a multiply, then a clean rerun.
    @(posedge clk); #1;
    h_key[0]   = NIST_H;
    ekj0[0]    = NIST_EK;
    len_aad[0] = 64'd0;
    len_ct[0]  = 64'd128;
    rx_tag[0]  = NIST_T2;
    start[0]   = 1'b1;
    @(posedge clk); #1;
    start[0]   = 1'b0;
    s_data[0]  = NIST_C;
    s_last[0]  = 1'b1;
    s_valid[0] = 1'b1;
    ok_hs      = 1'b0;
    for (int i = 0; i < 10 && !ok_hs; i++) begin
      ok_hs = s_ready[0];
      @(posedge clk); #1;
    end
    s_valid[0] = 1'b0;
    check("rst_mid_handshake", 128'(ok_hs), 128'(1));
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid_busy_before", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", 128'({busy[0], done[0], tag_ok[0], s_ready[0]}), 128'(0));
    check("rst_mid_tag_calc", tag_calc[0], 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    blkq = {NIST_C};
    run_txn(0, NIST_H, NIST_EK, 64'd0, 64'd128, NIST_T2, 1'b0, 1'b0, "rerun");
    check("rerun_const", tag_calc[0], NIST_T2);

    // start while busy on every digit width.
    for (int i = 0; i < N; i++) begin
      blkq = {NIST_C, rand128()};
      run_txn(i, NIST_H, NIST_EK, 64'd128, 64'd128, ref_tag(NIST_H, NIST_EK, 64'd128, 64'd128),
              1'b0, 1'b1, "poke");
    end

    // Random messages on all instances; about half carry a one-bit tag error.
    for (int r = 0; r < 9; r++) begin
      k  = r % N;
      nb = $urandom_range(1, 3);
      blkq = {};
      for (int i = 0; i < nb; i++) blkq.push_back(rand128());
      la = {32'd0, $urandom()};
      lc = {32'd0, $urandom()} | 64'd1;
      t  = rand128();
      rx = rand128();
      rx_tag[k] = ref_tag(t, rx, la, lc);
      if ($urandom_range(0, 1) == 1) rx_tag[k][$urandom_range(0, 127)] ^= 1'b1;
      run_txn(k, t, rx, la, lc, rx_tag[k], 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
